// File: rtl/ps2_byte_receiver_if.sv
// rtl/ps2_byte_receiver_if.sv - byte handshake between the PS/2 receiver and the mouse master SM
interface ps2_byte_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/ps2_byte_receiver.sv
// rtl/ps2_byte_receiver.sv - PS/2 device-to-host 11-bit frame receiver with parity/stop/timeout checks
module ps2_byte_receiver #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CLK_MOUSE_IN,
  input  logic                DATA_MOUSE_IN,
  ps2_byte_receiver_if.slave  byte_if
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        clk_a, clk_b, clk_c;
  logic        dat_a, dat_b;
  logic        fe;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic        par_acc, par_acc_nxt;
  logic        perr, perr_nxt;
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]  byte_q, byte_nxt;
  logic [1:0]  err_q, err_nxt;
  logic        ready_q, ready_nxt;

  // Pins idle high, so the synchronisers reset high to avoid a false edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_a <= 1'b1;
      clk_b <= 1'b1;
      clk_c <= 1'b1;
      dat_a <= 1'b1;
      dat_b <= 1'b1;
    end else begin
      clk_a <= CLK_MOUSE_IN;
      clk_b <= clk_a;
      clk_c <= clk_b;
      dat_a <= DATA_MOUSE_IN;
      dat_b <= dat_a;
    end
  end

  assign fe = ~clk_b & clk_c;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
      par_acc <= 1'b0;
      perr    <= 1'b0;
      tmo_cnt <= 16'd0;
      byte_q  <= 8'h00;
      err_q   <= 2'b00;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift_q <= shift_nxt;
      par_acc <= par_acc_nxt;
      perr    <= perr_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      byte_q  <= byte_nxt;
      err_q   <= err_nxt;
      ready_q <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_acc_nxt = par_acc;
    perr_nxt    = perr;
    tmo_cnt_nxt = tmo_cnt + 16'd1;
    byte_nxt    = byte_q;
    err_nxt     = 2'b00;
    ready_nxt   = 1'b0;

    case (state)
      IDLE: begin
        tmo_cnt_nxt = 16'd0;
        if (fe && byte_if.READ_ENABLE && !dat_b) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
          par_acc_nxt = 1'b0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_nxt   = {dat_b, shift_q[7:1]};
          par_acc_nxt = par_acc ^ dat_b;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          perr_nxt  = ~(par_acc ^ dat_b);
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          byte_nxt  = shift_q;
          err_nxt   = {~dat_b, perr};
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        tmo_cnt_nxt = 16'd0;
      end
    endcase

    // A clock fall always beats a coincident timeout.
    if (fe) begin
      tmo_cnt_nxt = 16'd0;
    end else if (state != IDLE && tmo_cnt == TMO_LIMIT) begin
      state_nxt   = IDLE;
      tmo_cnt_nxt = 16'd0;
    end
  end

  assign byte_if.BYTE_READ       = byte_q;
  assign byte_if.BYTE_ERROR_CODE = err_q;
  assign byte_if.BYTE_READY      = ready_q;

endmodule
